muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer that sits beside the execute stage and owns the HI/LO result registers. It accepts one operation per request and runs a radix-2 shift-add multiply or restoring divide over 32 cycles. It raises `Busy` so the pipeline controller holds the execute stage until the result is posted. It replaces the single-cycle `*` and `/` paths for MULT/MULTU/DIV/DIVU.

---
 rtl/muldiv_seq_pkg.sv | 20 ++
 rtl/muldiv_seq_if.sv | 26 ++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_seq.sv | 169 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// FSM state encodings, iteration constants and decode control-word bit indices.
package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_RUN   = 2'd1,
        MD_FIXUP = 2'd2,
        MD_DONE  = 2'd3
    } md_state_e;

    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = 5;

    // Control-word bit positions used by decode to drive Start/IsDiv/IsSigned
    localparam int MD_CW_MUL    = 0;
    localparam int MD_CW_DIV    = 1;
    localparam int MD_CW_SIGNED = 2;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the execute stage and muldiv_seq.
// master: execute-side requester; slave: the sequencer.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             IsDiv;
    logic             IsSigned;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             Busy;
    logic             Done;
    logic             DivByZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, IsDiv, IsSigned, OpA, OpB,
        input  Busy, Done, DivByZero, Hi, Lo
    );

    modport slave (
        input  Start, IsDiv, IsSigned, OpA, OpB,
        output Busy, Done, DivByZero, Hi, Lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply and restoring divide paths.
// Ports: is_div selects path; acc_hi/acc_lo current accumulator; divisor is |OpB|.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    // Multiply: 33-bit add keeps the carry, which shifts into P_hi MSB
    assign add_sum = {1'b0, acc_hi}
                   + {1'b0, (acc_lo[0] ? divisor : '0)};
    assign mul_hi  = add_sum[WIDTH:1];
    assign mul_lo  = {add_sum[0], acc_lo[WIDTH-1:1]};

    // Divide: acc_hi is the remainder, acc_lo holds dividend then quotient.
    // When ge, the difference fits in WIDTH bits so the low bits suffice.
    assign rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
    assign ge      = rem_sh >= {1'b0, divisor};
    assign diff    = rem_sh[WIDTH-1:0] - divisor;
    assign div_hi  = ge ? diff : rem_sh[WIDTH-1:0];
    assign div_lo  = {acc_lo[WIDTH-2:0], ge};

    assign nxt_hi  = is_div ? div_hi : mul_hi;
    assign nxt_lo  = is_div ? div_lo : mul_lo;
endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; 34-cycle latency.
// Ports: Clk, Reset (sync, active-high), bus (slave: Start/IsDiv/IsSigned/
// OpA/OpB in, Busy/Done/DivByZero/Hi/Lo out). Build macro MULDIV_SIGNED_EN
// enables signed operation; without it IsSigned is ignored.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    muldiv_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    md_state_e        state_q;
    md_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             is_div_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dz_q;

    logic             accept;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             div_zero;
    logic [WIDTH-1:0] base_hi;
    logic [WIDTH-1:0] base_lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign accept = bus.Start
                 && (state_q == MD_IDLE || state_q == MD_DONE);

`ifdef MULDIV_SIGNED_EN
    logic sa_q;
    logic sb_q;
    logic sa_in;
    logic sb_in;

    // Sign bits are captured pre-gated by the signed mode
    assign sa_in = bus.IsSigned & bus.OpA[WIDTH-1];
    assign sb_in = bus.IsSigned & bus.OpB[WIDTH-1];
    assign a_mag = sa_in ? -bus.OpA : bus.OpA;
    assign b_mag = sb_in ? -bus.OpB : bus.OpB;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sa_q <= 1'b0;
            sb_q <= 1'b0;
        end else if (accept) begin
            sa_q <= sa_in;
            sb_q <= sb_in;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = bus.IsSigned;
    assign a_mag = bus.OpA;
    assign b_mag = bus.OpB;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_q),
        .acc_hi  (acc_hi_q),
        .acc_lo  (acc_lo_q),
        .divisor (b_q),
        .nxt_hi  (step_hi),
        .nxt_lo  (step_lo)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= MD_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MD_IDLE:  if (bus.Start) state_d = MD_RUN;
            MD_RUN:   if (cnt_q == '0) state_d = MD_FIXUP;
            MD_FIXUP: state_d = MD_DONE;
            MD_DONE:  state_d = bus.Start ? MD_RUN : MD_IDLE;
            default:  state_d = MD_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.Busy      = (state_q == MD_RUN) || (state_q == MD_FIXUP);
        bus.Done      = (state_q == MD_DONE);
        bus.DivByZero = dz_q;
        bus.Hi        = hi_q;
        bus.Lo        = lo_q;
    end

    // Operand capture and iteration datapath
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else if (accept) begin
            cnt_q    <= CNT_W'(WIDTH - 1);
            is_div_q <= bus.IsDiv;
            acc_hi_q <= '0;
            acc_lo_q <= a_mag;
            a_q      <= a_mag;
            b_q      <= b_mag;
        end else if (state_q == MD_RUN) begin
            cnt_q    <= cnt_q - 1'b1;
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
        end
    end

    // Divide-by-zero result is forced before any sign fixup
    assign div_zero = is_div_q && (b_q == '0);
    assign base_hi  = div_zero ? a_q : acc_hi_q;
    assign base_lo  = div_zero ? '1  : acc_lo_q;

`ifdef MULDIV_SIGNED_EN
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    assign prod     = {base_hi, base_lo};
    assign prod_neg = -prod;

    always_comb begin
        res_hi = base_hi;
        res_lo = base_lo;
        if (!is_div_q) begin
            if (sa_q ^ sb_q) {res_hi, res_lo} = prod_neg;
        end else begin
            if (sa_q ^ sb_q) res_lo = -base_lo;
            if (sa_q)        res_hi = -base_hi;
        end
    end
`else
    assign res_hi = base_hi;
    assign res_lo = base_lo;
`endif

    // HI/LO only change at the end of FIXUP
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hi_q <= '0;
            lo_q <= '0;
            dz_q <= 1'b0;
        end else if (state_q == MD_FIXUP) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
            dz_q <= div_zero;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases, reset abort,
// back-to-back issue and randomized ops against an arithmetic model.
module tb_muldiv_seq;
    logic Clk;
    logic Reset;
    int   n_pass;
    int   n_total;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Returns {div_by_zero, hi, lo} from plain arithmetic
    function automatic logic [64:0] model(input bit div, input bit sgn,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
`ifndef MULDIV_SIGNED_EN
        sgn = 1'b0;
`endif
        sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (!div) begin
            p = 64'(sa * sb);
            return {1'b0, p};
        end
        if (b == 32'd0) begin
            // quotient all-ones, remainder |a|, then signed correction
            if (sgn && a[31]) return {1'b1, a, 32'd1};
            return {1'b1, a, 32'hFFFF_FFFF};
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Issues one op from the current cycle and waits for Done
    task automatic run_op(input string tag, input bit div, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b);
        logic [64:0] exp;
        int n;
        bit seen;
        exp = model(div, sgn, a, b);
        bus.Start    = 1'b1;
        bus.IsDiv    = div;
        bus.IsSigned = sgn;
        bus.OpA      = a;
        bus.OpB      = b;
        tick();
        bus.Start = 1'b0;
        bus.OpA   = $urandom;
        bus.OpB   = $urandom;
        bus.IsDiv = $urandom_range(0, 1);
        n = 1;
        seen = 1'b0;
        chk({tag, "_busy"}, 64'(bus.Busy), 64'd1);
        while (!seen && n < 60) begin
            if (n == 5) begin
                chk({tag, "_hold_hi"}, 64'(bus.Hi), 64'(prev_hi));
                chk({tag, "_hold_lo"}, 64'(bus.Lo), 64'(prev_lo));
            end
            tick();
            n++;
            if (bus.Done) seen = 1'b1;
        end
        chk({tag, "_lat"}, 64'(n), 64'd34);
        chk({tag, "_busy_done"}, 64'(bus.Busy), 64'd0);
        chk({tag, "_hi"}, 64'(bus.Hi), 64'(exp[63:32]));
        chk({tag, "_lo"}, 64'(bus.Lo), 64'(exp[31:0]));
        chk({tag, "_dz"}, 64'(bus.DivByZero), 64'(exp[64]));
        prev_hi = exp[63:32];
        prev_lo = exp[31:0];
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, 64'(bus.Busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.Done), 64'd0);
        chk({tag, "_dz"}, 64'(bus.DivByZero), 64'd0);
        chk({tag, "_hi"}, 64'(bus.Hi), 64'd0);
        chk({tag, "_lo"}, 64'(bus.Lo), 64'd0);
        prev_hi = 32'd0;
        prev_lo = 32'd0;
    endtask

    initial begin
        int done_cnt;
        bit div;
        bit sgn;
        logic [31:0] a;
        logic [31:0] b;
        n_pass = 0;
        n_total = 0;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        Reset = 1'b1;
        bus.Start = 1'b0;
        bus.IsDiv = 1'b0;
        bus.IsSigned = 1'b0;
        bus.OpA = 32'd0;
        bus.OpB = 32'd0;
        repeat (3) tick();
        check_reset_state("rst");
        Reset = 1'b0;
        tick();

        run_op("mulu_ff", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2);
        tick();
        run_op("muls_m3", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5);
        tick();
        run_op("divu_100", 1'b1, 1'b0, 32'd100, 32'd7);
        tick();
        run_op("divs_m7", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        tick();
        run_op("div_zero", 1'b1, 1'b0, 32'd5, 32'd0);
        tick();
        run_op("divs_zero", 1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0);
        tick();
        run_op("divs_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();

        // Second Start in RUN ignored, then reset mid-op aborts
        bus.Start = 1'b1;
        bus.IsDiv = 1'b0;
        bus.IsSigned = 1'b0;
        bus.OpA = 32'd6;
        bus.OpB = 32'd7;
        tick();
        bus.Start = 1'b0;
        repeat (4) tick();
        bus.Start = 1'b1;
        bus.OpA = 32'd2;
        bus.OpB = 32'd2;
        tick();
        bus.Start = 1'b0;
        chk("ignore_busy", 64'(bus.Busy), 64'd1);
        repeat (4) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_reset_state("abort");
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.Done) done_cnt++;
        end
        chk("abort_no_done", 64'(done_cnt), 64'd0);

        // Reset wins over Start in the same cycle
        Reset = 1'b1;
        bus.Start = 1'b1;
        tick();
        Reset = 1'b0;
        bus.Start = 1'b0;
        check_reset_state("rst_start");
        tick();
        chk("rst_start_idle", 64'(bus.Busy), 64'd0);

        // Restart, ignored mid-run Start, then back-to-back issue
        run_op("restart", 1'b0, 1'b0, 32'd6, 32'd7);
        run_op("b2b_div", 1'b1, 1'b0, 32'd1000, 32'd9);
        run_op("b2b_mul", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);

        for (int k = 0; k < 40; k++) begin
            div = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 300));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", k), div, sgn, a, b);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
